ahb_lite_master: RTL and testbench

- AHB-Lite initiator that drives the USB endpoint's AHB-Lite slave port.
- Accepts one burst command at a time from a local controller (test sequencer or DMA front end).
- Issues pipelined NONSEQ/SEQ transfers with fixed-address (FIFO) or incrementing addressing, then returns read data and a completion/error status.
- Handles slave wait states and the two-cycle AHB-Lite ERROR response.

---
 rtl/ahb_lite_master.sv | 211 +++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: runs one burst command at a time as pipelined NONSEQ/SEQ
// transfers, returning read beats and a done/error status.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 7,
    parameter int BEAT_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic                  cmdWrite,
    input  logic [ADDR_WIDTH-1:0] cmdAddr,
    input  logic [1:0]            cmdSize,
    input  logic                  cmdIncr,
    input  logic [BEAT_WIDTH-1:0] cmdBeats,
    input  logic [31:0]           wrData,
    output logic                  wrPop,
    output logic                  rdValid,
    output logic [31:0]           rdData,
    output logic                  done,
    output logic                  doneError,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [31:0]           hrdata,
    output logic                  hsel,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic [1:0]            hsize,
    output logic                  hwrite,
    output logic [2:0]            hburst,
    output logic [31:0]           hwdata
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BR_SINGLE = 3'b000;
    localparam logic [2:0] BR_INCR   = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_haddr, w_haddr;
    logic [1:0]            r_htrans, w_htrans;
    logic [1:0]            r_hsize, w_hsize;
    logic                  r_hwrite, w_hwrite;
    logic [2:0]            r_hburst, w_hburst;
    logic [31:0]           r_hwdata, w_hwdata;
    logic                  r_incr, w_incr;
    logic [BEAT_WIDTH:0]   r_beats, w_beats;
    logic [BEAT_WIDTH:0]   r_issued, w_issued;
    logic [BEAT_WIDTH:0]   r_cmpl, w_cmpl;
    logic                  r_dphase, w_dphase;
    logic                  r_dwrite, w_dwrite;
    logic                  r_rdValid, w_rdValid;
    logic [31:0]           r_rdData, w_rdData;
    logic                  r_done, w_done;
    logic                  r_doneErr, w_doneErr;

    logic                  w_aphDone, w_dphOk, w_dphErr;
    logic [ADDR_WIDTH-1:0] w_step;

    assign w_aphDone = (r_htrans != TR_IDLE) && hready && !hresp;
    assign w_dphOk   = r_dphase && hready && !hresp && (r_state != S_ERR);
    assign w_dphErr  = r_dphase && hresp;
    assign w_step    = r_incr ? (ADDR_WIDTH'(1) << r_hsize) : '0;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= S_IDLE;
            r_haddr   <= '0;
            r_htrans  <= TR_IDLE;
            r_hsize   <= '0;
            r_hwrite  <= 1'b0;
            r_hburst  <= '0;
            r_hwdata  <= '0;
            r_incr    <= 1'b0;
            r_beats   <= '0;
            r_issued  <= '0;
            r_cmpl    <= '0;
            r_dphase  <= 1'b0;
            r_dwrite  <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
            r_done    <= 1'b0;
            r_doneErr <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_haddr   <= w_haddr;
            r_htrans  <= w_htrans;
            r_hsize   <= w_hsize;
            r_hwrite  <= w_hwrite;
            r_hburst  <= w_hburst;
            r_hwdata  <= w_hwdata;
            r_incr    <= w_incr;
            r_beats   <= w_beats;
            r_issued  <= w_issued;
            r_cmpl    <= w_cmpl;
            r_dphase  <= w_dphase;
            r_dwrite  <= w_dwrite;
            r_rdValid <= w_rdValid;
            r_rdData  <= w_rdData;
            r_done    <= w_done;
            r_doneErr <= w_doneErr;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_haddr   = r_haddr;
        w_htrans  = r_htrans;
        w_hsize   = r_hsize;
        w_hwrite  = r_hwrite;
        w_hburst  = r_hburst;
        w_hwdata  = r_hwdata;
        w_incr    = r_incr;
        w_beats   = r_beats;
        w_issued  = r_issued;
        w_cmpl    = r_cmpl;
        w_dphase  = r_dphase;
        w_dwrite  = r_dwrite;
        w_rdValid = 1'b0;
        w_rdData  = r_rdData;
        w_done    = 1'b0;
        w_doneErr = 1'b0;

        // A completing data phase retires here; an overlapping address phase re-arms it below.
        if (w_dphOk) begin
            w_cmpl   = r_cmpl + 1'b1;
            w_dphase = 1'b0;
            if (!r_dwrite) begin
                w_rdValid = 1'b1;
                w_rdData  = hrdata;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (cmdValid) begin
                    if (cmdSize == 2'd3) begin
                        w_done    = 1'b1;
                        w_doneErr = 1'b1;
                    end else begin
                        w_haddr  = cmdAddr;
                        w_htrans = TR_NONSEQ;
                        w_hsize  = cmdSize;
                        w_hwrite = cmdWrite;
                        w_hburst = (cmdBeats == BEAT_WIDTH'(1)) ? BR_SINGLE : BR_INCR;
                        w_incr   = cmdIncr;
                        w_beats  = {(cmdBeats == '0), cmdBeats};
                        w_issued = '0;
                        w_cmpl   = '0;
                        w_state  = S_ADDR;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (w_dphErr) begin
                    // Cancel any pending address phase; a one-cycle ERROR finishes at once.
                    w_htrans = TR_IDLE;
                    if (hready) begin
                        w_dphase  = 1'b0;
                        w_done    = 1'b1;
                        w_doneErr = 1'b1;
                        w_state   = S_IDLE;
                    end else begin
                        w_state = S_ERR;
                    end
                end else if (r_state == S_ADDR && w_aphDone) begin
                    w_dphase = 1'b1;
                    w_dwrite = r_hwrite;
                    if (r_hwrite)
                        w_hwdata = wrData;
                    w_issued = r_issued + 1'b1;
                    if (w_issued == r_beats) begin
                        w_htrans = TR_IDLE;
                        w_state  = S_DATA;
                    end else begin
                        w_haddr  = r_haddr + w_step;
                        w_htrans = TR_SEQ;
                    end
                end else if (r_state == S_DATA && w_dphOk && w_cmpl == r_beats) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end
            end
            S_ERR: begin
                if (hready) begin
                    w_dphase  = 1'b0;
                    w_done    = 1'b1;
                    w_doneErr = 1'b1;
                    w_state   = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign cmdReady  = (r_state == S_IDLE);
    assign wrPop     = (r_state == S_ADDR) && r_hwrite && w_aphDone;
    assign rdValid   = r_rdValid;
    assign rdData    = r_rdData;
    assign done      = r_done;
    assign doneError = r_doneErr;
    assign hsel      = (r_htrans != TR_IDLE);
    assign haddr     = r_haddr;
    assign htrans    = r_htrans;
    assign hsize     = r_hsize;
    assign hwrite    = r_hwrite;
    assign hburst    = r_hburst;
    assign hwdata    = r_hwdata;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: hand-timed bus cycles with immediate assertions.
module tb_ahb_lite_master;
    logic        clk = 1'b0;
    logic        nRst;
    logic        cmdValid, cmdReady, cmdWrite, cmdIncr;
    logic [6:0]  cmdAddr, cmdBeats;
    logic [1:0]  cmdSize;
    logic [31:0] wrData;
    logic        wrPop, rdValid, done, doneError;
    logic [31:0] rdData;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic        hsel, hwrite;
    logic [6:0]  haddr;
    logic [1:0]  htrans, hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;

    int n_assert = 0;
    int n_fail   = 0;
    int pops, rdcnt, donecnt;
    logic [31:0] wd [0:3];

    always #5 clk = ~clk;

    ahb_lite_master dut (
        .clk(clk), .nRst(nRst), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdSize(cmdSize), .cmdIncr(cmdIncr),
        .cmdBeats(cmdBeats), .wrData(wrData), .wrPop(wrPop), .rdValid(rdValid),
        .rdData(rdData), .done(done), .doneError(doneError), .hready(hready),
        .hresp(hresp), .hrdata(hrdata), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hburst(hburst), .hwdata(hwdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; tally pulses seen in the cycle being left and feed the write FIFO.
    task automatic cyc();
        if (wrPop === 1'b1) pops++;
        if (rdValid === 1'b1) rdcnt++;
        if (done === 1'b1) donecnt++;
        @(posedge clk);
        #1;
        wrData = (pops < 4) ? wd[pops] : 32'h0;
    endtask

    task automatic cmd(input logic wr, input logic [6:0] a, input logic [1:0] sz,
                       input logic inc, input logic [6:0] bt);
        cmdValid = 1'b1; cmdWrite = wr; cmdAddr = a; cmdSize = sz; cmdIncr = inc; cmdBeats = bt;
        pops = 0; rdcnt = 0; donecnt = 0;
        wrData = wd[0];
    endtask

    initial begin
        int k;
        logic found;
        nRst = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdSize = '0;
        cmdIncr = 1'b0; cmdBeats = '0; wrData = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        pops = 0; rdcnt = 0; donecnt = 0;
        wd[0] = 32'h0; wd[1] = 32'h0; wd[2] = 32'h0; wd[3] = 32'h0;
        #1;
        chk("rst_cmdReady", cmdReady, 1);
        chk("rst_htrans", htrans, 0);
        chk("rst_hsel", hsel, 0);
        chk("rst_done", done, 0);
        chk("rst_rdValid", rdValid, 0);
        chk("rst_wrPop", wrPop, 0);
        @(posedge clk); @(posedge clk); #1;
        nRst = 1'b1;
        cyc();

        // Single word write
        wd[0] = 32'hDEADBEEF; wd[1] = 32'h0;
        cmd(1'b1, 7'h04, 2'd2, 1'b1, 7'd1);
        #1; chk("w1_cmdReady", cmdReady, 1);
        cyc(); cmdValid = 1'b0; #1;
        chk("w1_htrans", htrans, 2);
        chk("w1_haddr", haddr, 7'h04);
        chk("w1_hburst", hburst, 0);
        chk("w1_hsize", hsize, 2);
        chk("w1_hwrite", hwrite, 1);
        chk("w1_hsel", hsel, 1);
        chk("w1_wrPop", wrPop, 1);
        chk("w1_cmdReady_busy", cmdReady, 0);
        cyc(); #1;
        chk("w1_htrans_idle", htrans, 0);
        chk("w1_hwdata", hwdata, 32'hDEADBEEF);
        chk("w1_done_early", done, 0);
        cyc(); #1;
        chk("w1_done", done, 1);
        chk("w1_doneError", doneError, 0);
        chk("w1_cmdReady_end", cmdReady, 1);
        cyc(); #1;
        chk("w1_done_pulse", done, 0);

        // 4-beat incrementing read wrapping past 0x7F
        cmd(1'b0, 7'h7C, 2'd2, 1'b1, 7'd4);
        cyc(); cmdValid = 1'b0; #1;
        chk("r4_t1_htrans", htrans, 2);
        chk("r4_t1_haddr", haddr, 7'h7C);
        chk("r4_hburst", hburst, 1);
        cyc(); hrdata = 32'h11111111; #1;
        chk("r4_t2_htrans", htrans, 3);
        chk("r4_t2_haddr", haddr, 7'h00);
        cyc(); hrdata = 32'h22222222; #1;
        chk("r4_t3_rdValid", rdValid, 1);
        chk("r4_t3_rdData", rdData, 32'h11111111);
        chk("r4_t3_haddr", haddr, 7'h04);
        cyc(); hrdata = 32'h33333333; #1;
        chk("r4_t4_rdData", rdData, 32'h22222222);
        chk("r4_t4_htrans", htrans, 3);
        chk("r4_t4_haddr", haddr, 7'h08);
        cyc(); hrdata = 32'h44444444; #1;
        chk("r4_t5_rdData", rdData, 32'h33333333);
        chk("r4_t5_htrans", htrans, 0);
        chk("r4_t5_done", done, 0);
        cyc(); #1;
        chk("r4_t6_rdData", rdData, 32'h44444444);
        chk("r4_t6_rdValid", rdValid, 1);
        chk("r4_t6_done", done, 1);
        chk("r4_t6_doneError", doneError, 0);
        cyc(); #1;
        chk("r4_rdcnt", rdcnt, 4);

        // Fixed-address 3-beat write, two wait states on beat 2
        wd[0] = 32'hA0000001; wd[1] = 32'hA0000002; wd[2] = 32'hA0000003; wd[3] = 32'h0;
        cmd(1'b1, 7'h00, 2'd2, 1'b0, 7'd3);
        cyc(); cmdValid = 1'b0; #1;
        chk("fw_t1_htrans", htrans, 2);
        chk("fw_t1_wrPop", wrPop, 1);
        chk("fw_hburst", hburst, 1);
        cyc(); #1;
        chk("fw_t2_htrans", htrans, 3);
        chk("fw_t2_haddr", haddr, 7'h00);
        chk("fw_t2_hwdata", hwdata, 32'hA0000001);
        cyc(); hready = 1'b0; #1;
        chk("fw_t3_wrPop", wrPop, 0);
        chk("fw_t3_hwdata", hwdata, 32'hA0000002);
        cyc(); #1;
        chk("fw_t4_htrans", htrans, 3);
        chk("fw_t4_haddr", haddr, 7'h00);
        chk("fw_t4_hwdata", hwdata, 32'hA0000002);
        chk("fw_t4_wrPop", wrPop, 0);
        cyc(); hready = 1'b1; #1;
        chk("fw_t5_wrPop", wrPop, 1);
        chk("fw_t5_haddr", haddr, 7'h00);
        cyc(); #1;
        chk("fw_t6_htrans", htrans, 0);
        chk("fw_t6_hwdata", hwdata, 32'hA0000003);
        cyc(); #1;
        chk("fw_done", done, 1);
        chk("fw_doneError", doneError, 0);
        chk("fw_pops", pops, 3);

        // ERROR on beat 2 of a 4-beat read
        cmd(1'b0, 7'h10, 2'd2, 1'b1, 7'd4);
        cyc(); cmdValid = 1'b0; #1;
        chk("er_t1_htrans", htrans, 2);
        cyc(); hrdata = 32'hCAFE0001; #1;
        chk("er_t2_haddr", haddr, 7'h14);
        cyc(); hready = 1'b0; hresp = 1'b1; hrdata = 32'hBAD0BAD0; #1;
        chk("er_t3_rdData", rdData, 32'hCAFE0001);
        chk("er_t3_htrans", htrans, 3);
        cyc(); hready = 1'b1; hresp = 1'b1; #1;
        chk("er_t4_htrans", htrans, 0);
        chk("er_t4_hsel", hsel, 0);
        chk("er_t4_done", done, 0);
        chk("er_t4_rdValid", rdValid, 0);
        cyc(); hresp = 1'b0; #1;
        chk("er_done", done, 1);
        chk("er_doneError", doneError, 1);
        chk("er_rdValid", rdValid, 0);
        chk("er_cmdReady", cmdReady, 1);
        cyc(); #1;
        chk("er_rdcnt", rdcnt, 1);
        chk("er_htrans_idle", htrans, 0);

        // Illegal size: no bus activity, immediate error completion
        cmd(1'b0, 7'h08, 2'd3, 1'b1, 7'd2);
        cyc(); cmdValid = 1'b0; #1;
        chk("sz3_done", done, 1);
        chk("sz3_doneError", doneError, 1);
        chk("sz3_htrans", htrans, 0);
        chk("sz3_cmdReady", cmdReady, 1);

        // 128-beat byte read with address wrap
        hrdata = 32'h0000005A;
        cmd(1'b0, 7'h7E, 2'd0, 1'b1, 7'd0);
        cyc(); cmdValid = 1'b0; #1;
        chk("b128_t1_haddr", haddr, 7'h7E);
        chk("b128_hburst", hburst, 1);
        cyc(); #1;
        chk("b128_t2_haddr", haddr, 7'h7F);
        cyc(); #1;
        chk("b128_t3_haddr", haddr, 7'h00);
        chk("b128_t3_htrans", htrans, 3);
        k = 3; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(); k++;
            if (done === 1'b1) found = 1'b1;
        end
        chk("b128_done_seen", found, 1);
        chk("b128_latency", k, 130);
        chk("b128_doneError", doneError, 0);
        cyc(); #1;
        chk("b128_rdcnt", rdcnt, 128);

        // Reset mid-burst, then a normal single read
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        cmd(1'b1, 7'h40, 2'd2, 1'b1, 7'd4);
        cyc(); cmdValid = 1'b0;
        cyc(); #1;
        nRst = 1'b0; #1;
        chk("mr_htrans", htrans, 0);
        chk("mr_hsel", hsel, 0);
        chk("mr_haddr", haddr, 0);
        chk("mr_hwdata", hwdata, 0);
        chk("mr_hwrite", hwrite, 0);
        chk("mr_wrPop", wrPop, 0);
        chk("mr_cmdReady", cmdReady, 1);
        cyc(); cyc(); nRst = 1'b1;
        cyc(); cyc(); cyc(); #1;
        chk("mr_no_done", donecnt, 0);
        cmd(1'b0, 7'h20, 2'd2, 1'b1, 7'd1);
        cyc(); cmdValid = 1'b0; #1;
        chk("mr_t1_htrans", htrans, 2);
        chk("mr_t1_haddr", haddr, 7'h20);
        chk("mr_t1_hwrite", hwrite, 0);
        cyc(); hrdata = 32'h5A5A5A5A; #1;
        cyc(); #1;
        chk("mr_done", done, 1);
        chk("mr_doneError", doneError, 0);
        chk("mr_rdValid", rdValid, 1);
        chk("mr_rdData", rdData, 32'h5A5A5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
